jr_target_resolve: RTL
======================

# jr_target_resolve

ID-stage consumer of the jump-register hazard signals (`ForwardJ`, `stallJ`) in the 5-stage MIPS pipeline. It holds the front end while a JR/JALR source register is unavailable. Once the hazard clears, it selects the source operand from the register file, EX/MEM or MEM/WB, and latches the jump target. One cycle later it issues a single-cycle PC redirect and IF/ID flush.

## Interface
Parameters:
- `MAX_STALL`, default 3: stall cycles tolerated in WAIT before `err_stall` is set.

Ports:
- `clk` in 1: pipeline clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_is_jr` in 1: ID instruction is JR or JALR.
- `flush_in` in 1: flush of ID from an older instruction; highest priority.
- `ForwardJ` in 2: source select. 00 = register file, 01 = EX/MEM, 10 = MEM/WB, 11 = treated as 00.
- `stallJ` in 1: jump source not yet available.
- `rf_rdata` in 32: register-file rs read data.
- `exmem_alu_out` in 32: EX/MEM ALU result.
- `memwb_wdata` in 32: MEM/WB write-back data.
- `hold` out 1: stall PC and IF/ID, inject bubble into ID/EX (combinational).
- `pc_redirect` out 1: one-cycle pulse, load PC from `pc_target`.
- `flush_ifid` out 1: one-cycle pulse, squash the IF/ID contents.
- `pc_target` out 32: registered jump target, bits [1:0] forced to 00.
- `misaligned` out 1: pulses with `pc_redirect` when the selected source had bits [1:0] ≠ 00.
- `err_stall` out 1: sticky, set when the WAIT count exceeds `MAX_STALL`.
- `jr_count` out 16: number of redirects issued, wraps at 0xFFFF→0.

## Operation
- States: IDLE, WAIT, REDIRECT. Reset state is IDLE.
- Resolve condition: `id_valid && id_is_jr`.
- IDLE:
  - Resolve and `stallJ` → WAIT. `hold`=1 in the same cycle. Stall counter ← 1.
  - Resolve and no stall → latch the selected source into `pc_target` and `misaligned_q`, go to REDIRECT.
  - Otherwise stay in IDLE.
- WAIT:
  - `stallJ`=1 → `hold`=1, stall counter +1, saturating at `MAX_STALL`+1.
  - When the counter would exceed `MAX_STALL`, `err_stall` is set. No other effect; the block keeps waiting.
  - `stallJ`=0 → `hold`=0, latch the target using the current `ForwardJ`, go to REDIRECT.
- REDIRECT:
  - `pc_redirect`=1, `flush_ifid`=1, `misaligned`=`misaligned_q`, `jr_count` +1.
  - ID inputs are ignored; the instruction in ID is the wrong path and is being flushed.
  - Unconditional return to IDLE next cycle.
- `flush_in`:
  - In any state, the next state is IDLE and the stall counter clears.
  - In REDIRECT it suppresses `pc_redirect`, `flush_ifid` and `misaligned`, and `jr_count` does not increment.
  - In IDLE/WAIT it forces `hold`=0.
  - `err_stall` is not cleared.
- Target selection width: all sources are 32 bits. Bits [1:0] are reported via `misaligned`, then zeroed.

## Timing
- Reset values: `hold`=0, `pc_redirect`=0, `flush_ifid`=0, `pc_target`=0, `misaligned`=0, `err_stall`=0, `jr_count`=0. State is IDLE and the stall counter is 0.
- Latency without hazard: JR in ID at cycle N → `pc_redirect`/`flush_ifid` at N+1.
- Latency with hazard: k stall cycles → redirect at N+k+1. `hold` is high for exactly k cycles, N..N+k-1.
- `hold` is combinational from `stallJ`, `flush_in` and state; no registered delay.
- Other outputs are register-driven (`pc_target`, `err_stall`, `jr_count`) or state-decoded (`pc_redirect`, `flush_ifid`, `misaligned`).
- Back-to-back JR: the second JR cannot be in ID during REDIRECT (it is flushed). The earliest accepted next JR is at N+2.
- Reset asserted mid-WAIT or mid-REDIRECT: outputs drop to reset values immediately (asynchronous); no pulse is emitted after deassertion.

## Test plan
- JR, `stallJ`=0, `ForwardJ`=00, `rf_rdata`=0x0040_0010 at cycle N → `pc_target`=0x0040_0010, `pc_redirect`=`flush_ifid`=1 at N+1 only, `hold` never high, `jr_count`=1.
- JR with `stallJ` high for 2 cycles, then `ForwardJ`=01, `exmem_alu_out`=0x0000_1234 → `hold` high N..N+1, `pc_target`=0x0000_1234 and redirect at N+3.
- JR with `ForwardJ`=10, `memwb_wdata`=0x0000_2002 → `pc_target`=0x0000_2000, `misaligned`=1 for one cycle with the redirect.
- `stallJ` held for 5 cycles, `MAX_STALL`=3 → `err_stall` rises on the 4th WAIT cycle and stays high. Redirect occurs after `stallJ` drops.
- `flush_in`=1 during REDIRECT → no `pc_redirect`/`flush_ifid`, `jr_count` unchanged, state IDLE next cycle. `flush_in` during WAIT → `hold`=0 immediately.
- `rst_n` low for one cycle mid-WAIT → all outputs at reset values asynchronously. A JR presented after release resolves normally with `jr_count`=1.

Source files
------------

// File: rtl/jr_target_resolve_if.sv
// ID-stage jump-register resolve bus: hazard/forwarding inputs from the pipeline
// and the PC redirect / front-end hold outputs back to it.
interface jr_target_resolve_if #(
  parameter int DATA_W = 32
);
  logic              id_valid;
  logic              id_is_jr;
  logic              flush_in;
  logic [1:0]        ForwardJ;
  logic              stallJ;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] exmem_alu_out;
  logic [DATA_W-1:0] memwb_wdata;
  logic              hold;
  logic              pc_redirect;
  logic              flush_ifid;
  logic [DATA_W-1:0] pc_target;
  logic              misaligned;
  logic              err_stall;
  logic [15:0]       jr_count;

  modport master (
    output id_valid, id_is_jr, flush_in, ForwardJ, stallJ,
           rf_rdata, exmem_alu_out, memwb_wdata,
    input  hold, pc_redirect, flush_ifid, pc_target, misaligned,
           err_stall, jr_count
  );

  modport slave (
    input  id_valid, id_is_jr, flush_in, ForwardJ, stallJ,
           rf_rdata, exmem_alu_out, memwb_wdata,
    output hold, pc_redirect, flush_ifid, pc_target, misaligned,
           err_stall, jr_count
  );
endinterface

// File: rtl/jr_target_resolve.sv
// Holds the front end while a JR/JALR source is unavailable, then latches the
// forwarded jump target and issues a one-cycle PC redirect with IF/ID flush.
module jr_target_resolve #(
  parameter int MAX_STALL = 3,
  parameter int DATA_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  jr_target_resolve_if.slave jrBus
);

  localparam int CNT_W = $clog2(MAX_STALL + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [CNT_W-1:0]  stallCnt;
  logic              errStall;
  logic [15:0]       jrCount;
  logic [DATA_W-1:0] srcP0;
  logic [DATA_W-1:0] targetP1;
  logic              misalignedP1;
  logic              resolve;
  logic              latchEn;
  logic              startStall;
  logic              keepStall;
  logic              vldP1;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_SAT) return CNT_SAT;
    return cnt + CNT_W'(1);
  endfunction

  // Encoding 11 is unused by the hazard unit and falls back to the register file
  function automatic logic [DATA_W-1:0] selectSrc(
    input logic [1:0]        fwd,
    input logic [DATA_W-1:0] rfData,
    input logic [DATA_W-1:0] exmemData,
    input logic [DATA_W-1:0] memwbData
  );
    case (fwd)
      2'b01:   return exmemData;
      2'b10:   return memwbData;
      default: return rfData;
    endcase
  endfunction

  // Stage p0: source selection and hazard decode in ID
  assign resolve    = jrBus.id_valid && jrBus.id_is_jr;
  assign srcP0      = selectSrc(jrBus.ForwardJ, jrBus.rf_rdata,
                                jrBus.exmem_alu_out, jrBus.memwb_wdata);
  assign startStall = !jrBus.flush_in && (state == ST_IDLE) && resolve && jrBus.stallJ;
  assign keepStall  = !jrBus.flush_in && (state == ST_WAIT) && jrBus.stallJ;
  assign latchEn    = !jrBus.flush_in && !jrBus.stallJ &&
                      (((state == ST_IDLE) && resolve) || (state == ST_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (resolve) stateNext = jrBus.stallJ ? ST_WAIT : ST_REDIRECT;
      end
      ST_WAIT: begin
        if (!jrBus.stallJ) stateNext = ST_REDIRECT;
      end
      ST_REDIRECT: stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
    if (jrBus.flush_in) stateNext = ST_IDLE;
  end

  // Reset gates hold so the front end is released the instant rst_n falls
  always_comb begin
    jrBus.hold        = 1'b0;
    vldP1             = 1'b0;
    jrBus.pc_redirect = 1'b0;
    jrBus.flush_ifid  = 1'b0;
    jrBus.misaligned  = 1'b0;
    if (rst_n && (startStall || keepStall)) jrBus.hold = 1'b1;
    if ((state == ST_REDIRECT) && !jrBus.flush_in) begin
      vldP1             = 1'b1;
      jrBus.pc_redirect = 1'b1;
      jrBus.flush_ifid  = 1'b1;
      jrBus.misaligned  = misalignedP1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      errStall <= 1'b0;
    end else begin
      if (startStall)     stallCnt <= CNT_W'(1);
      else if (keepStall) stallCnt <= satInc(stallCnt);
      else                stallCnt <= '0;
      if (keepStall && (stallCnt >= CNT_MAX)) errStall <= 1'b1;
    end
  end

  // Stage p1: latched jump target, consumed by the redirect cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      targetP1     <= '0;
      misalignedP1 <= 1'b0;
    end else if (latchEn) begin
      targetP1     <= {srcP0[DATA_W-1:2], 2'b00};
      misalignedP1 <= |srcP0[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     jrCount <= '0;
    else if (vldP1) jrCount <= jrCount + 16'd1;
  end

  assign jrBus.pc_target = targetP1;
  assign jrBus.err_stall = errStall;
  assign jrBus.jr_count  = jrCount;

endmodule
